// File: rtl/btn_pulse_if.sv
// Button front-end bundle: raw pins in, clean pulses/levels out, plus FSM state for debug.
// Pulses are single-cycle strobes with no back-pressure: trig/split are valid for exactly one cycle, and there is no ready.
interface btn_pulse_if;
    logic       btn_trig_raw;
    logic       btn_split_raw;
    logic       trig;
    logic       split;
    logic       trig_level;
    logic       split_level;
    logic [1:0] trig_state;
    logic [1:0] split_state;

    modport master (
        output btn_trig_raw, btn_split_raw,
        input  trig, split, trig_level, split_level, trig_state, split_state
    );

    modport slave (
        input  btn_trig_raw, btn_split_raw,
        output trig, split, trig_level, split_level, trig_state, split_state
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Two-channel button debouncer producing one clean pulse per press, with trig-over-split
// arbitration so the two pulses never share a cycle.
module btn_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic         clk,
    input  logic         reset,
    btn_pulse_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_HELD   = 2'd2;
    localparam logic [1:0] S_DISARM = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Channel 0 is trig, channel 1 is split.
    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0][1:0]       r_state;
    logic [1:0][1:0]       w_state_nxt;
    logic [1:0][CNT_W-1:0] r_cnt;
    logic [1:0][CNT_W-1:0] w_cnt_nxt;
    logic [1:0]            w_press;
    logic [1:0]            w_level_nxt;
    logic [1:0]            r_level;

    logic r_trig;
    logic r_split;
    logic r_trig_pend;
    logic r_split_pend;
    logic w_trig_nxt;
    logic w_split_nxt;
    logic w_trig_pend_nxt;
    logic w_split_pend_nxt;

    assign w_raw = {bus.btn_split_raw, bus.btn_trig_raw};

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            w_state_nxt[ch] = r_state[ch];
            w_cnt_nxt[ch]   = r_cnt[ch];
            w_press[ch]     = 1'b0;
            case (r_state[ch])
                S_IDLE: begin
                    if (r_sync2[ch]) begin
                        w_state_nxt[ch] = S_ARM;
                        w_cnt_nxt[ch]   = '0;
                    end
                end
                S_ARM: begin
                    if (!r_sync2[ch]) begin
                        w_state_nxt[ch] = S_IDLE;
                    end else if (r_cnt[ch] == CNT_LAST) begin
                        w_state_nxt[ch] = S_HELD;
                        w_press[ch]     = 1'b1;
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] + CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!r_sync2[ch]) begin
                        w_state_nxt[ch] = S_DISARM;
                        w_cnt_nxt[ch]   = '0;
                    end
                end
                default: begin
                    // Release bounce returns to HELD without a new press.
                    if (r_sync2[ch]) begin
                        w_state_nxt[ch] = S_HELD;
                    end else if (r_cnt[ch] == CNT_LAST) begin
                        w_state_nxt[ch] = S_IDLE;
                    end else begin
                        w_cnt_nxt[ch] = r_cnt[ch] + CNT_ONE;
                    end
                end
            endcase
            w_level_nxt[ch] = (w_state_nxt[ch] == S_HELD) || (w_state_nxt[ch] == S_DISARM);
        end
    end

    // A pending split always drains first; otherwise trig wins and split waits one cycle.
    always_comb begin
        w_trig_nxt       = 1'b0;
        w_split_nxt      = 1'b0;
        w_trig_pend_nxt  = 1'b0;
        w_split_pend_nxt = 1'b0;
        if (r_split_pend) begin
            w_split_nxt      = 1'b1;
            w_trig_pend_nxt  = r_trig_pend | w_press[0];
            w_split_pend_nxt = w_press[1];
        end else if (r_trig_pend || w_press[0]) begin
            w_trig_nxt       = 1'b1;
            w_trig_pend_nxt  = r_trig_pend & w_press[0];
            w_split_pend_nxt = w_press[1];
        end else begin
            w_split_nxt = w_press[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_state      <= {S_IDLE, S_IDLE};
            r_cnt        <= '0;
            r_level      <= '0;
            r_trig       <= 1'b0;
            r_split      <= 1'b0;
            r_trig_pend  <= 1'b0;
            r_split_pend <= 1'b0;
        end else begin
            r_sync1      <= w_raw;
            r_sync2      <= r_sync1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_level      <= w_level_nxt;
            r_trig       <= w_trig_nxt;
            r_split      <= w_split_nxt;
            r_trig_pend  <= w_trig_pend_nxt;
            r_split_pend <= w_split_pend_nxt;
        end
    end

    assign bus.trig        = r_trig;
    assign bus.split       = r_split;
    assign bus.trig_level  = r_level[0];
    assign bus.split_level = r_level[1];
    assign bus.trig_state  = r_state[0];
    assign bus.split_state = r_state[1];

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed press/bounce/reset scenarios followed by random button
// activity, checked against a run-length debounce model and a first-free-slot pulse scheduler.
module tb_btn_pulse_gen;

    localparam int DEB = 4;

    logic clk;
    logic reset;

    btn_pulse_if bus ();

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected pulses, encoded as {edge index, channel}; channel 0 = trig, 1 = split.
    logic [31:0] exp_q[$];
    bit          busy[int];
    int          edge_cnt = 0;
    int          run[2];
    bit          dl[2];
    bit          pipe0[2];
    bit          pipe1[2];
    bit          exp_lvl[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------- reference model ----------------
    // A debounced level flips once the sampled raw input has disagreed with it for DEB+1
    // consecutive samples; the effect is visible two edges later (synchronizer delay).
    always @(posedge clk) begin
        bit rise[2];
        int slot;
        edge_cnt++;
        if (!reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                run[ch] = 0; dl[ch] = 1'b0; pipe0[ch] = 1'b0; pipe1[ch] = 1'b0; exp_lvl[ch] = 1'b0;
            end
            exp_q.delete();
            busy.delete();
        end else begin
            bit raw[2];
            raw[0] = bus.btn_trig_raw;
            raw[1] = bus.btn_split_raw;
            for (int ch = 0; ch < 2; ch++) begin
                rise[ch]    = 1'b0;
                exp_lvl[ch] = pipe1[ch];
                pipe1[ch]   = pipe0[ch];
                if (raw[ch] == dl[ch]) begin
                    run[ch] = 0;
                end else begin
                    run[ch]++;
                    if (run[ch] == DEB + 1) begin
                        dl[ch]   = raw[ch];
                        run[ch]  = 0;
                        rise[ch] = raw[ch];
                    end
                end
                pipe0[ch] = dl[ch];
            end
            // Trig claims its slot before split; each takes the first free cycle.
            for (int ch = 0; ch < 2; ch++) begin
                if (rise[ch]) begin
                    slot = edge_cnt + 2;
                    while (busy.exists(slot)) slot++;
                    busy[slot] = 1'b1;
                    exp_q.push_back({slot[30:0], ch[0]});
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [31:0] act;
        logic [31:0] exp;
        #2;
        check("trig_level", {31'd0, bus.trig_level}, {31'd0, exp_lvl[0]});
        check("split_level", {31'd0, bus.split_level}, {31'd0, exp_lvl[1]});
        while (exp_q.size() > 0 && exp_q[0][31:1] < edge_cnt[30:0]) begin
            exp = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: actual=none expected=%0h (edge %0d)", exp, edge_cnt);
        end
        check("no_overlap", {31'd0, bus.trig & bus.split}, 32'd0);
        if (bus.trig || bus.split) begin
            act = {edge_cnt[30:0], bus.split};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: actual=%0h expected=none", act);
            end else begin
                exp = exp_q.pop_front();
                check("pulse", act, exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit t, input bit s, input int n);
        bus.btn_trig_raw  = t;
        bus.btn_split_raw = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_reset(input bit v);
        reset = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset             = 1'b0;
        bus.btn_trig_raw  = 1'b0;
        bus.btn_split_raw = 1'b0;
        @(negedge clk);

        // Buttons toggling under reset, then release with buttons low.
        for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        drive(1'b0, 1'b0, 1);
        set_reset(1'b1);
        drive(1'b0, 1'b0, 10);

        // Clean trig press held long.
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 12);

        // Split bounce then hold.
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 15);
        drive(1'b0, 1'b0, 12);

        // Simultaneous press.
        drive(1'b1, 1'b1, 15);
        drive(1'b0, 1'b0, 12);

        // Release glitch, clean release, second press.
        drive(1'b1, 1'b0, 12);
        drive(1'b0, 1'b0, 2);
        drive(1'b1, 1'b0, 6);
        drive(1'b0, 1'b0, 12);
        drive(1'b1, 1'b0, 12);
        drive(1'b0, 1'b0, 12);

        // Reset while debouncing, button held through reset release.
        drive(1'b1, 1'b0, 5);
        set_reset(1'b0);
        drive(1'b1, 1'b0, 3);
        set_reset(1'b1);
        drive(1'b1, 1'b0, 15);
        drive(1'b0, 1'b0, 12);

        // Random activity with occasional resets.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                set_reset(1'b0);
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
                set_reset(1'b1);
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        drive(1'b0, 1'b0, 20);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
